sata_host_oob_ctrl: RTL



---
 rtl/sata_oob_pkg.sv | 32 +++
 rtl/sata_oob_timeout.sv | 28 ++
 rtl/sata_host_oob_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/sata_oob_pkg.sv
// Shared constants, state encoding and primitive helpers for the SATA host OOB controller.
package sata_oob_pkg;

  localparam logic [31:0] ALIGN_DATA = 32'h7B4A4ABC;
  localparam logic [3:0]  ALIGN_K    = 4'b0001;
  localparam logic [31:0] SYNC_DATA  = 32'hB5B5957C;
  localparam logic [3:0]  SYNC_K     = 4'b0001;
  localparam logic [31:0] D102_DATA  = 32'h4A4A4A4A;
  localparam logic [3:0]  D102_K     = 4'b0000;
  localparam logic [3:0]  PRIM_K     = 4'b0001;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_COMINIT,
    ST_WAIT_COMINIT,
    ST_COMWAKE,
    ST_WAIT_COMWAKE,
    ST_WAIT_NO_COMWAKE,
    ST_SEND_D102,
    ST_SEND_ALIGN,
    ST_READY
  } oob_state_e;

  function automatic logic is_align(input logic [31:0] data, input logic [3:0] charisk);
    return (data == ALIGN_DATA) && (charisk == ALIGN_K);
  endfunction

  function automatic logic is_primitive(input logic [3:0] charisk);
    return charisk == PRIM_K;
  endfunction

endpackage

// File: rtl/sata_oob_timeout.sv
// Per-state wait counter: cleared on every state entry, flags expiry at TIMEOUT_CYCLES-1.
module sata_oob_timeout #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      count <= '0;
    end else if (count != LAST) begin
      // Holding at LAST keeps the untimed states (RESET, READY) from wrapping.
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/sata_host_oob_ctrl.sv
// Host-side SATA OOB sequencer: COMINIT/COMWAKE, D10.2/ALIGN speed handshake, then
// forwards link-layer words once the link is ready.
module sata_host_oob_ctrl
  import sata_oob_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int NONALIGN_COUNT = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic        tx_cominit,
  output logic        tx_comwake,
  input  logic        tx_oob_done,
  input  logic        rx_cominit_stb,
  input  logic        rx_comwake_stb,
  input  logic        rx_idle,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_charisk,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_charisk,
  input  logic [31:0] user_tx_data,
  input  logic [3:0]  user_tx_charisk,
  output logic        ready,
  output logic [7:0]  retries
);

  localparam int NW = $clog2(NONALIGN_COUNT + 1);
  localparam logic [NW-1:0] NONALIGN_LAST = NW'(NONALIGN_COUNT - 1);

  oob_state_e    state_q, state_d;
  logic [NW-1:0] nonalign_q;
  logic          expired;
  logic          timed_state;
  logic          timeout_fire;
  logic          rx_align;
  logic          rx_nonalign_prim;

  assign rx_align         = is_align(rx_data, rx_charisk);
  assign rx_nonalign_prim = is_primitive(rx_charisk) && !rx_align;
  assign timed_state      = (state_q != ST_RESET) && (state_q != ST_READY);
  assign timeout_fire     = timed_state && expired;

  sata_oob_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .clear  (state_d != state_q),
    .expired(expired)
  );

  // NOTE: state_d takes its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:           state_d = ST_COMINIT;
      ST_COMINIT:         if (tx_oob_done)    state_d = ST_WAIT_COMINIT;
      ST_WAIT_COMINIT:    if (rx_cominit_stb) state_d = ST_COMWAKE;
      ST_COMWAKE:         if (tx_oob_done)    state_d = ST_WAIT_COMWAKE;
      ST_WAIT_COMWAKE:    if (rx_comwake_stb) state_d = ST_WAIT_NO_COMWAKE;
      ST_WAIT_NO_COMWAKE: if (!rx_idle)       state_d = ST_SEND_D102;
      ST_SEND_D102:       if (rx_align)       state_d = ST_SEND_ALIGN;
      ST_SEND_ALIGN:
        if (rx_nonalign_prim && (nonalign_q == NONALIGN_LAST)) state_d = ST_READY;
      ST_READY:           if (rx_cominit_stb) state_d = ST_RESET;
      default:            state_d = ST_RESET;
    endcase
    if (timeout_fire) state_d = ST_RESET;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_RESET;
      nonalign_q <= '0;
      tx_cominit <= 1'b0;
      tx_comwake <= 1'b0;
      tx_data    <= SYNC_DATA;
      tx_charisk <= SYNC_K;
      ready      <= 1'b0;
      retries    <= 8'd0;
    end else begin
      state_q <= state_d;

      if ((state_q == ST_SEND_ALIGN) && rx_nonalign_prim) nonalign_q <= nonalign_q + 1'b1;
      else                                                  nonalign_q <= '0;

      // Burst requests fire in the entry cycle of their state.
      tx_cominit <= (state_d == ST_COMINIT) && (state_q != ST_COMINIT);
      tx_comwake <= (state_d == ST_COMWAKE) && (state_q != ST_COMWAKE);

      case (state_q)
        ST_SEND_D102:  begin tx_data <= D102_DATA;    tx_charisk <= D102_K;          end
        ST_SEND_ALIGN: begin tx_data <= ALIGN_DATA;   tx_charisk <= ALIGN_K;         end
        ST_READY:      begin tx_data <= user_tx_data; tx_charisk <= user_tx_charisk; end
        default:       begin tx_data <= SYNC_DATA;    tx_charisk <= SYNC_K;          end
      endcase

      ready <= (state_q == ST_READY);
      if (timeout_fire && (retries != 8'hFF)) retries <= retries + 8'd1;
    end
  end

endmodule
